tick_gen: RTL and testbench
===========================

# tick_gen

Parametrised multi-channel timebase generator for the calculator and later lab designs. It produces N_CH independent one-cycle tick enables and matching 50 % square waves from the 100 MHz system clock. Each channel's divisor can be changed at runtime without glitches, each channel has its own enable, and a shared phase-sync input restarts every channel together. The block sits beside the top level and feeds the display scan, debounce and blink logic.

## Interface
- CNT_W, 20: width of every divisor and counter.
- N_CH, 2: number of channels; must be at least 1.
- DEF_DIVS, {20'd500000, 20'd50000}: packed N_CH*CNT_W reset divisors. Channel i uses bits [i*CNT_W +: CNT_W]. The default gives ch0 a 1 kHz sq and ch1 a 100 Hz sq.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- en  in  N_CH  per-channel run enable.
- sync  in  1  one-cycle strobe that restarts all channels in phase.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  $clog2(N_CH) (minimum 1)  target channel of the write.
- wr_div  in  CNT_W  new divisor D; legal range is 1..2^CNT_W-1.
- wr_err  out  1  one-cycle pulse when a write is rejected.
- tick  out  N_CH  one-cycle pulse per channel period.
- sq  out  N_CH  square wave per channel, toggling on every tick.

## Operation
- Per-channel state: `cnt` (counter), `act_div` (active divisor), `shd_div` (shadow divisor), `pend` (shadow waiting to be applied).
- Reset values: cnt=0, act_div=shd_div=DEF_DIVS slice, pend=0, tick=0, sq=0, wr_err=0.
- Running, en[i]=1:
  - If cnt==act_div-1: cnt<=0, tick<=1, sq<=~sq, and act_div<=shd_div if pend is set (then pend<=0).
  - Otherwise: cnt<=cnt+1, tick<=0.
- Stopped, en[i]=0: cnt and sq hold, tick=0.
- Write, wr_en=1 with a legal channel and wr_div!=0: shd_div<=wr_div and pend<=1.
  - If en[i]=0, or the channel is at terminal count in that same cycle, the new value becomes act_div on that edge. The write wins over the old shadow.
- Rejected write (wr_ch>=N_CH or wr_div==0): no state change; wr_err<=1 for one cycle.
- sync=1, all channels: cnt<=0, tick<=0, sq<=0, and any pending shadow is applied.
  - sync overrides a terminal count in the same cycle.
  - A write in the same cycle as sync is applied as the active divisor.
- D=1: tick is held high continuously and sq toggles every cycle.
- Reset mid-period: every output returns to its reset value immediately (asynchronous). Divisors return to DEF_DIVS.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- From reset release, sync, or a 0→1 edge of en[i] with cnt=0, the first tick appears after exactly D enabled edges. After that, tick has a period of D cycles and sq a period of 2D cycles.
- Divisor change on a running channel:
  - The current period completes with the old D.
  - The next period uses the new D. No short or runt period is produced.
  - Several writes within one period: the last one wins.
- Channels are fully independent except for sync.
- wr_err is asserted on the edge after the bad write.

## Structure
- Package `tick_gen_pkg`:
  - CLK_HZ = 100_000_000.
  - Divisor helper constants for 1 kHz scan and 100 Hz debounce.
  - Channel-index typedef.
- Sub-module `tick_gen_ch`: one channel, holding the counter, shadow/pend logic and tick/sq registers. The top level instantiates it N_CH times with a generate loop and handles write decode and the error pulse.

## Test plan
- Reset release with defaults → ch0 tick first at cycle 50000, then every 50000 cycles; ch1 sq period is 1,000,000 cycles.
- Write D=4 to ch0 in mid-period → the old period finishes unchanged, then ticks arrive every 4 cycles and sq is high 4 / low 4.
- Write D=3 to ch1 with en[1]=0, then raise en → first tick arrives 3 enabled cycles after en rises.
- wr_ch=2 with N_CH=2, or wr_div=0 → wr_err pulses for one cycle and ticks continue unchanged.
- sync asserted on ch0's terminal cycle → no tick that cycle; all cnt=0, sq=0; next ticks arrive D cycles later, in phase.
- Assert rst mid-count → tick=0, sq=0 and counters cleared immediately; default divisors restored.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared constants and types for the multi-channel timebase generator
package tick_gen_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned SCAN_HZ     = 1_000;
    localparam int unsigned DEBOUNCE_HZ = 100;

    // A channel with divisor D ticks every D cycles and its square wave has a
    // period of 2*D cycles, so a square-wave rate f needs D = CLK_HZ / (2*f).
    function automatic int unsigned sq_div(input int unsigned sq_hz);
        return CLK_HZ / (2 * sq_hz);
    endfunction

    localparam int unsigned DIV_SCAN     = sq_div(SCAN_HZ);      // 50_000
    localparam int unsigned DIV_DEBOUNCE = sq_div(DEBOUNCE_HZ);  // 500_000

    // Width of the channel-select port; a single-channel build still gets one bit.
    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Channel index wide enough for any sensible build; the write port is
    // zero-extended into this type so range checks never overflow.
    localparam int CH_IDX_MAX_W = 8;
    typedef logic [CH_IDX_MAX_W-1:0] ch_idx_t;

endpackage

// File: rtl/tick_gen_ch.sv
// rtl/tick_gen_ch.sv - one timebase channel: counter, shadow divisor, tick and square wave
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   en          run enable; when low the counter and square wave hold
//   sync        restart strobe shared by all channels
//   wr          validated divisor write aimed at this channel
//   wr_div      divisor carried by the write (never zero here)
//   tick        registered one-cycle pulse per period
//   sq          registered square wave, toggles on every tick
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int                 CNT_W   = 20,
    parameter logic [CNT_W-1:0]   DEF_DIV = CNT_W'(DIV_SCAN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_div_q, act_div_d;
    logic [CNT_W-1:0] shd_div_q, shd_div_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             term;

    always_comb begin
        cnt_d     = cnt_q;
        act_div_d = act_div_q;
        shd_div_d = shd_div_q;
        pend_d    = pend_q;
        tick_d    = 1'b0;
        sq_d      = sq_q;

        // ">=" rather than "==" so that a counter left beyond a freshly
        // shortened divisor wraps at once instead of running to 2^CNT_W.
        term = en && (cnt_q >= (act_div_q - CNT_W'(1)));

        if (sync) begin
            // Restart in phase; a same-cycle write beats any older shadow.
            cnt_d = '0;
            sq_d  = 1'b0;
            if (wr) begin
                act_div_d = wr_div;
                shd_div_d = wr_div;
                pend_d    = 1'b0;
            end else if (pend_q) begin
                act_div_d = shd_div_q;
                pend_d    = 1'b0;
            end
        end else begin
            if (en) begin
                if (term) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    sq_d   = ~sq_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            if (wr) begin
                shd_div_d = wr_div;
                // Stopped or at a period boundary: no period is in flight,
                // so the new divisor can take effect immediately.
                if (!en || term) begin
                    act_div_d = wr_div;
                    pend_d    = 1'b0;
                end else begin
                    pend_d    = 1'b1;
                end
            end else if (term && pend_q) begin
                act_div_d = shd_div_q;
                pend_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            act_div_q <= DEF_DIV;
            shd_div_q <= DEF_DIV;
            pend_q    <= 1'b0;
            tick_q    <= 1'b0;
            sq_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            act_div_q <= act_div_d;
            shd_div_q <= shd_div_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            sq_q      <= sq_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;

endmodule

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - multi-channel tick and square-wave timebase generator
//
// Ports:
//   clk, rst    100 MHz system clock, asynchronous active-high reset
//   en          per-channel run enable
//   sync        one-cycle strobe restarting every channel in phase
//   wr_en       divisor write strobe
//   wr_ch       target channel of the write
//   wr_div      new divisor, legal range 1..2^CNT_W-1
//   wr_err      one-cycle pulse after a rejected write
//   tick        per-channel one-cycle pulse each period
//   sq          per-channel 50 % square wave
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int                      CNT_W    = 20,
    parameter int                      N_CH     = 2,
    parameter logic [N_CH*CNT_W-1:0]   DEF_DIVS = {CNT_W'(DIV_DEBOUNCE), CNT_W'(DIV_SCAN)}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         en,
    input  logic                    sync,
    input  logic                    wr_en,
    input  logic [ch_w(N_CH)-1:0]   wr_ch,
    input  logic [CNT_W-1:0]        wr_div,
    output logic                    wr_err,
    output logic [N_CH-1:0]         tick,
    output logic [N_CH-1:0]         sq
);

    ch_idx_t wr_idx;
    logic    wr_ok;
    logic    wr_err_d, wr_err_q;

    // A write is accepted only for an existing channel and a non-zero divisor;
    // anything else leaves every channel untouched and raises wr_err.
    always_comb begin
        wr_idx   = ch_idx_t'(wr_ch);
        wr_ok    = wr_en && (wr_idx < ch_idx_t'(N_CH)) && (wr_div != '0);
        wr_err_d = wr_en && !wr_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_gen_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIVS[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr_ok && (wr_idx == ch_idx_t'(i))),
            .wr_div  (wr_div),
            .tick    (tick[i]),
            .sq      (sq[i])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - self-checking bench for tick_gen with a cycle scoreboard
module tb_tick_gen;

    localparam int CNT_W = 8;
    localparam int N_CH  = 3;
    // ch0 = 5, ch1 = 3, ch2 = 6
    localparam logic [N_CH*CNT_W-1:0] DEF_DIVS = {8'd6, 8'd3, 8'd5};

    logic             clk = 1'b0;
    logic             rst;
    logic [N_CH-1:0]  en;
    logic             sync;
    logic             wr_en;
    logic [1:0]       wr_ch;
    logic [CNT_W-1:0] wr_div;
    logic             wr_err;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  sq;

    tick_gen #(
        .CNT_W    (CNT_W),
        .N_CH     (N_CH),
        .DEF_DIVS (DEF_DIVS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .sync   (sync),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .wr_err (wr_err),
        .tick   (tick),
        .sq     (sq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_CH-1:0] tick;
        logic [N_CH-1:0] sq;
        logic            err;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc_no   = 0;

    int              m_cnt [N_CH];
    int              m_act [N_CH];
    int              m_shd [N_CH];
    bit              m_pend[N_CH];
    logic [N_CH-1:0] m_tick;
    logic [N_CH-1:0] m_sq;
    logic            m_err;

    function automatic int def_div(input int ch);
        case (ch)
            0:       return 5;
            1:       return 3;
            default: return 6;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc_no, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_cnt[i]  = 0;
            m_act[i]  = def_div(i);
            m_shd[i]  = def_div(i);
            m_pend[i] = 1'b0;
        end
        m_tick = '0;
        m_sq   = '0;
        m_err  = 1'b0;
    endtask

    // Predicts the registered outputs after the coming clock edge.
    task automatic model_edge();
        bit legal;
        bit hit;
        legal = wr_en && (int'(wr_ch) < N_CH) && (wr_div != 0);
        m_err = wr_en && !legal;
        for (int i = 0; i < N_CH; i++) begin
            hit       = legal && (int'(wr_ch) == i);
            m_tick[i] = 1'b0;
            if (sync) begin
                m_cnt[i] = 0;
                m_sq[i]  = 1'b0;
                if (hit) begin
                    m_act[i]  = int'(wr_div);
                    m_shd[i]  = int'(wr_div);
                    m_pend[i] = 1'b0;
                end else if (m_pend[i]) begin
                    m_act[i]  = m_shd[i];
                    m_pend[i] = 1'b0;
                end
            end else if (!en[i]) begin
                if (hit) begin
                    m_act[i]  = int'(wr_div);
                    m_shd[i]  = int'(wr_div);
                    m_pend[i] = 1'b0;
                end
            end else if (m_cnt[i] == m_act[i] - 1) begin
                m_cnt[i]  = 0;
                m_tick[i] = 1'b1;
                m_sq[i]   = ~m_sq[i];
                if (hit) begin
                    m_act[i] = int'(wr_div);
                    m_shd[i] = int'(wr_div);
                end else if (m_pend[i]) begin
                    m_act[i] = m_shd[i];
                end
                m_pend[i] = 1'b0;
            end else begin
                m_cnt[i]++;
                if (hit) begin
                    m_shd[i]  = int'(wr_div);
                    m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc();
        exp_t e;
        model_edge();
        e = {m_tick, m_sq, m_err};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_no++;
        e = exp_q.pop_front();
        check("tick",   32'(tick),   32'(e.tick));
        check("sq",     32'(sq),     32'(e.sq));
        check("wr_err", 32'(wr_err), 32'(e.err));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic write(input int ch, input int div);
        wr_en  = 1'b1;
        wr_ch  = 2'(ch);
        wr_div = CNT_W'(div);
        cyc();
        wr_en  = 1'b0;
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
    endtask

    task automatic measure(input int ch, input int limit, output int lat);
        lat = 0;
        for (int k = 1; k <= limit; k++) begin
            cyc();
            if (tick[ch] && lat == 0) lat = k;
            if (lat != 0) break;
        end
    endtask

    task automatic wait_terminal(input int ch);
        for (int k = 0; k < 40 && (m_cnt[ch] != m_act[ch] - 1); k++) cyc();
    endtask

    initial begin
        int lat;
        int ch;
        int dv;

        rst    = 1'b1;
        en     = '1;
        sync   = 1'b0;
        wr_en  = 1'b0;
        wr_ch  = '0;
        wr_div = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_tick",   32'(tick),   32'd0);
        check("reset_sq",     32'(sq),     32'd0);
        check("reset_wr_err", 32'(wr_err), 32'd0);
        model_reset();
        rst = 1'b0;

        // Defaults: ch0 first tick after exactly 5 edges.
        measure(0, 20, lat);
        check("first_tick_ch0", 32'(lat), 32'd5);
        run(7);

        // Mid-period divisor change on a running channel.
        run(2);
        write(0, 4);
        run(20);

        // Last write within a period wins.
        write(2, 2);
        write(2, 3);
        run(20);

        // Pending shadow applied by sync.
        run(1);
        write(2, 4);
        pulse_sync();
        run(10);

        // Rejected writes: bad channel, zero divisor.
        write(3, 5);
        write(0, 0);
        run(4);

        // Write to a stopped channel, then start it.
        en[1] = 1'b0;
        run(3);
        pulse_sync();
        write(1, 2);
        run(3);
        en[1] = 1'b1;
        measure(1, 10, lat);
        check("en_rise_latency_ch1", 32'(lat), 32'd2);
        run(6);

        // sync on ch0's terminal cycle, with a same-cycle write to ch2.
        wait_terminal(0);
        sync   = 1'b1;
        wr_en  = 1'b1;
        wr_ch  = 2'd2;
        wr_div = 8'd5;
        cyc();
        sync   = 1'b0;
        wr_en  = 1'b0;
        measure(0, 10, lat);
        check("post_sync_latency_ch0", 32'(lat), 32'd4);
        run(12);

        // Write landing exactly on a terminal count.
        wait_terminal(1);
        write(1, 4);
        run(12);

        // D = 1: tick held high.
        write(1, 1);
        run(6);

        // Asynchronous reset mid-count.
        rst = 1'b1;
        #1;
        check("async_rst_tick",   32'(tick),   32'd0);
        check("async_rst_sq",     32'(sq),     32'd0);
        check("async_rst_wr_err", 32'(wr_err), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        measure(2, 12, lat);
        check("default_restored_ch2", 32'(lat), 32'd6);
        run(8);

        // Mixed random traffic.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) en[$urandom_range(0, N_CH-1)] ^= 1'b1;
            sync = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 5) == 0) begin
                ch = $urandom_range(0, 3);
                dv = $urandom_range(0, 7);
                // Shrinking a stopped channel below its held count is left undefined.
                if (ch >= N_CH || dv == 0 || en[ch] || sync || m_cnt[ch] < dv) begin
                    wr_en  = 1'b1;
                    wr_ch  = 2'(ch);
                    wr_div = CNT_W'(dv);
                end
            end
            cyc();
            wr_en = 1'b0;
            sync  = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
